pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage, and the successor to the single PC register.
- Holds the fetch PC and computes the next PC internally: sequential +4, branch/jump redirect, or trap vector.
- Buffers a redirect that arrives while fetch is stalled, so it is not lost.
- Optionally predicts returns with a small return-address stack (RAS).

Parameters:
DATA_WIDTH, 32, width of PC and all address ports
RESET_VECTOR, 0, value loaded into pc_o on reset (must be 4-byte aligned)
RAS_DEPTH, 4, number of RAS entries (power of two, >=2; used only with PC_RAS_EN)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-high reset
en_i  input  1  advance enable; 0 = stall (PC frozen)
branch_i  input  1  branch/jump redirect request
branchTarget_i  input  DATA_WIDTH  redirect target for branch_i
trap_i  input  1  trap/exception redirect request
trapVector_i  input  DATA_WIDTH  trap target
call_i  input  1  current fetch is a call (RAS push of pcPlus4_o)
ret_i  input  1  current fetch is a return (RAS pop prediction)
pc_o  output  DATA_WIDTH  current fetch PC (registered)
pcPlus4_o  output  DATA_WIDTH  pc_o + 4, combinational, modulo 2^DATA_WIDTH
misaligned_o  output  1  registered one-cycle pulse: accepted redirect target had bits[1:0] != 0
pending_o  output  1  a redirect is buffered awaiting en_i
rasEmpty_o  output  1  RAS holds no entries

Behaviour:
Reset (async assert, any cycle, including mid-stall or with a redirect pending):
- pc_o = RESET_VECTOR.
- pending cleared; misaligned_o = 0.
- RAS count = 0, pointer = 0; rasEmpty_o = 1.

Next-PC selection at a rising edge with en_i = 1, first match wins:
- 1. trap_i -> trapVector_i
- 2. branch_i -> branchTarget_i
- 3. pending valid -> buffered target
- 4. RAS_EN and ret_i and RAS not empty -> RAS top
- 5. otherwise pcPlus4_o

Enabled-edge side effects:
- pending is cleared on every enabled edge, whichever source wins.
- A current-cycle redirect supersedes a buffered one.

Stall (en_i = 0):
- pc_o holds.
- trap_i: buffer trapVector_i, marked as a trap; always overwrites the buffer.
- branch_i: buffer branchTarget_i only if the buffer does not already hold a trap.
- trap_i and branch_i together: trap is buffered.
- pending_o goes high the cycle after the first buffered redirect and stays high until the enabled edge that consumes it.

Alignment:
- Any redirect target (current or buffered) is loaded with bits[1:0] forced to 0.
- misaligned_o = 1 for exactly the cycle after such a load if the original bits[1:0] != 0, else 0.
- Sequential and RAS paths never assert misaligned_o.

Width/wrap:
- All arithmetic is DATA_WIDTH-bit unsigned and wraps (all-ones minus 3, plus 4 = 0).
- No overflow flag.

Latency:
- Redirect presented with en_i = 1 appears on pc_o one cycle later.
- Buffered redirect appears one cycle after en_i returns high.

Optional Feature:
Macro PC_RAS_EN.

Defined:
- RAS of RAS_DEPTH x DATA_WIDTH entries, circular.
- Acts only on enabled edges, and only when no trap_i, branch_i or pending is active; otherwise the stack is untouched.
- call_i pushes pcPlus4_o. When full, the push overwrites the oldest entry and count stays at RAS_DEPTH.
- ret_i with count > 0: pops and selects the top as next PC.
- ret_i with count = 0: falls through to pcPlus4_o; no underflow.
- call_i and ret_i together: next PC = old top, and the top is replaced by pcPlus4_o (count unchanged). If empty, this behaves as a push and next PC = pcPlus4_o.
- rasEmpty_o = (count == 0), registered.

Undefined:
- call_i and ret_i are ignored.
- No RAS storage is generated.
- rasEmpty_o tied to 1.
- Priority item 4 is absent.

Test Plan:
- Release reset with RESET_VECTOR=0x100, en_i=1, no requests, 4 cycles -> pc_o = 0x100, 0x104, 0x108, 0x10C; misaligned_o=0; pending_o=0.
- en_i=0 for 3 cycles; branch_i=1 target 0x2000 in stall cycle 1; trap_i=1 vector 0x80 in stall cycle 2; then en_i=1 -> pc_o held throughout the stall; pending_o=1 from stall cycle 2; first enabled edge gives pc_o=0x80 (trap kept); pending_o=0 after.
- Branch to 0x1003 with en_i=1 -> next cycle pc_o=0x1000, misaligned_o=1 for one cycle, then 0.
- pc_o=0xFFFFFFFC, en_i=1 -> next pc_o=0x00000000; pcPlus4_o=0x00000000 while pc_o=0xFFFFFFFC.
- PC_RAS_EN, RAS_DEPTH=4: calls at 0x10, 0x20, 0x30, 0x40, 0x50, then 5 rets:
  - 4 rets return 0x54, 0x44, 0x34, 0x24 (the oldest entry, 0x14, was overwritten).
  - rasEmpty_o=1 after the 4th ret.
  - 5th ret falls through to pc+4.
- Assert rst_i asynchronously mid-stall with pending_o=1 and RAS non-empty -> immediately pc_o=RESET_VECTOR, pending_o=0, rasEmpty_o=1, misaligned_o=0.

Source files
------------

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Fetch-stage program-counter generator. Holds the fetch PC and
//                selects the next PC from trap vector, branch target, a
//                redirect buffered during stall, an optional return-address
//                stack prediction, or sequential +4.
//                Optional feature macro: PC_RAS_EN (return-address stack).
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_gen #(
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int                    RAS_DEPTH    = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  branch_i,
   input  logic [DATA_WIDTH-1:0] branchTarget_i,
   input  logic                  trap_i,
   input  logic [DATA_WIDTH-1:0] trapVector_i,
   input  logic                  call_i,
   input  logic                  ret_i,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic [DATA_WIDTH-1:0] pcPlus4_o,
   output logic                  misaligned_o,
   output logic                  pending_o,
   output logic                  rasEmpty_o
);

   localparam logic [DATA_WIDTH-1:0] C_FOUR = DATA_WIDTH'(4);

   logic [DATA_WIDTH-1:0] r_pc;
   logic                  r_pend_valid;
   logic                  r_pend_trap;
   logic [DATA_WIDTH-1:0] r_pend_target;
   logic                  r_misaligned;

   logic [DATA_WIDTH-1:0] w_pc_plus4;
   logic                  w_redirect;
   logic [DATA_WIDTH-1:0] w_redirect_raw;
   logic [DATA_WIDTH-1:0] w_redirect_aligned;
   logic                  w_redirect_mis;
   logic                  w_ras_sel;
   logic [DATA_WIDTH-1:0] w_ras_target;

   assign w_pc_plus4 = r_pc + C_FOUR;

   // Any redirect source (current or buffered) wins over RAS and sequential flow
   assign w_redirect = trap_i | branch_i | r_pend_valid;

   // Redirect target: trap beats branch, and a current request beats the buffer
   always_comb begin
      w_redirect_raw = r_pend_target;
      if (trap_i) begin
         w_redirect_raw = trapVector_i;
      end else if (branch_i) begin
         w_redirect_raw = branchTarget_i;
      end
   end

   assign w_redirect_aligned = {w_redirect_raw[DATA_WIDTH-1:2], 2'b00};
   assign w_redirect_mis     = |w_redirect_raw[1:0];

`ifdef PC_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   // Circular stack: r_sp is the next write slot, top lives at r_sp - 1.
   // Pushing when full simply overwrites the oldest entry.
   logic [DATA_WIDTH-1:0] r_ras [RAS_DEPTH];
   logic [PTR_W-1:0]      r_sp;
   logic [CNT_W-1:0]      r_count;
   logic                  r_ras_empty;

   logic [PTR_W-1:0]      w_top_idx;
   logic                  w_ras_act;
   logic                  w_ras_we;
   logic [PTR_W-1:0]      w_ras_widx;
   logic [PTR_W-1:0]      w_sp_nxt;
   logic [CNT_W-1:0]      w_count_nxt;

   assign w_top_idx    = r_sp - 1'b1;
   assign w_ras_act    = en_i & ~w_redirect;
   assign w_ras_sel    = w_ras_act & ret_i & (r_count != '0);
   assign w_ras_target = r_ras[w_top_idx];

   // Stack update decision: pop, replace-top (call+ret), or push
   always_comb begin
      w_ras_we    = 1'b0;
      w_ras_widx  = r_sp;
      w_sp_nxt    = r_sp;
      w_count_nxt = r_count;
      if (w_ras_act) begin
         if (ret_i && (r_count != '0)) begin
            if (call_i) begin
               w_ras_we   = 1'b1;
               w_ras_widx = w_top_idx;
            end else begin
               w_sp_nxt    = w_top_idx;
               w_count_nxt = r_count - 1'b1;
            end
         end else if (call_i) begin
            w_ras_we   = 1'b1;
            w_ras_widx = r_sp;
            w_sp_nxt   = r_sp + 1'b1;
            if (r_count != CNT_W'(RAS_DEPTH)) begin
               w_count_nxt = r_count + 1'b1;
            end
         end
      end
   end

   // Stack storage; contents are meaningless until counted, so no reset
   always_ff @(posedge clk_i) begin
      if (w_ras_we) begin
         r_ras[w_ras_widx] <= w_pc_plus4;
      end
   end

   // Stack pointer, occupancy and registered empty flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sp        <= '0;
         r_count     <= '0;
         r_ras_empty <= 1'b1;
      end else begin
         r_sp        <= w_sp_nxt;
         r_count     <= w_count_nxt;
         r_ras_empty <= (w_count_nxt == '0);
      end
   end

   assign rasEmpty_o = r_ras_empty;
`else
   logic w_unused_ras;

   assign w_unused_ras = call_i ^ ret_i;
   assign w_ras_sel    = 1'b0;
   assign w_ras_target = '0;
   assign rasEmpty_o   = 1'b1;
`endif

   // PC, redirect buffer and misalignment pulse
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pc          <= RESET_VECTOR;
         r_pend_valid  <= 1'b0;
         r_pend_trap   <= 1'b0;
         r_pend_target <= '0;
         r_misaligned  <= 1'b0;
      end else begin
         r_misaligned <= 1'b0;
         if (en_i) begin
            r_pend_valid <= 1'b0;
            r_pend_trap  <= 1'b0;
            if (w_redirect) begin
               r_pc         <= w_redirect_aligned;
               r_misaligned <= w_redirect_mis;
            end else if (w_ras_sel) begin
               r_pc <= w_ras_target;
            end else begin
               r_pc <= w_pc_plus4;
            end
         end else begin
            // Stalled: a trap always takes the buffer, a branch never displaces a trap
            if (trap_i) begin
               r_pend_valid  <= 1'b1;
               r_pend_trap   <= 1'b1;
               r_pend_target <= trapVector_i;
            end else if (branch_i && !(r_pend_valid && r_pend_trap)) begin
               r_pend_valid  <= 1'b1;
               r_pend_trap   <= 1'b0;
               r_pend_target <= branchTarget_i;
            end
         end
      end
   end

   assign pc_o         = r_pc;
   assign pcPlus4_o    = w_pc_plus4;
   assign misaligned_o = r_misaligned;
   assign pending_o    = r_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Self-checking bench for pc_gen: directed scenarios plus a
//                randomized run against a queue-based reference model.
//                Exercises the return-address stack when PC_RAS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

   localparam int          W     = 32;
   localparam int          RAS_D = 4;
   localparam logic [31:0] RV    = 32'h0000_0100;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        en_i = 1'b0, branch_i = 1'b0, trap_i = 1'b0, call_i = 1'b0, ret_i = 1'b0;
   logic [31:0] branchTarget_i = '0, trapVector_i = '0;
   logic [31:0] pc_o, pcPlus4_o;
   logic        misaligned_o, pending_o, rasEmpty_o;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   logic [31:0] m_pc;
   logic        m_pv, m_ptrap, m_mis;
   logic [31:0] m_pt;
   logic [31:0] m_ras [$];

   pc_gen #(.DATA_WIDTH(W), .RESET_VECTOR(RV), .RAS_DEPTH(RAS_D)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
      .branch_i(branch_i), .branchTarget_i(branchTarget_i),
      .trap_i(trap_i), .trapVector_i(trapVector_i),
      .call_i(call_i), .ret_i(ret_i),
      .pc_o(pc_o), .pcPlus4_o(pcPlus4_o), .misaligned_o(misaligned_o),
      .pending_o(pending_o), .rasEmpty_o(rasEmpty_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_pc = RV; m_pv = 1'b0; m_ptrap = 1'b0; m_pt = '0; m_mis = 1'b0;
      m_ras.delete();
   endtask

   // Behavioural next state from the current inputs
   task automatic model_edge();
      logic [31:0] p4, tgt;
      logic        redir;
      p4    = m_pc + 32'd4;
      m_mis = 1'b0;
      tgt   = '0;
      if (en_i) begin
         redir = 1'b1;
         if (trap_i)        tgt = trapVector_i;
         else if (branch_i) tgt = branchTarget_i;
         else if (m_pv)     tgt = m_pt;
         else               redir = 1'b0;
         if (redir) begin
            m_pc  = tgt & ~32'h3;
            m_mis = (tgt[1:0] != 2'b00);
         end else begin
`ifdef PC_RAS_EN
            if (ret_i && m_ras.size() > 0) begin
               m_pc = m_ras[$];
               if (call_i) m_ras[$] = p4;
               else        void'(m_ras.pop_back());
            end else begin
               if (call_i) begin
                  m_ras.push_back(p4);
                  if (m_ras.size() > RAS_D) void'(m_ras.pop_front());
               end
               m_pc = p4;
            end
`else
            m_pc = p4;
`endif
         end
         m_pv = 1'b0; m_ptrap = 1'b0;
      end else begin
         if (trap_i) begin
            m_pv = 1'b1; m_ptrap = 1'b1; m_pt = trapVector_i;
         end else if (branch_i && !(m_pv && m_ptrap)) begin
            m_pv = 1'b1; m_ptrap = 1'b0; m_pt = branchTarget_i;
         end
      end
   endtask

   // Apply one cycle of inputs, clock it, advance the model; outputs stable on return
   task automatic cyc(input logic en, input logic br, input logic [31:0] bt,
                      input logic tr, input logic [31:0] tv,
                      input logic ca, input logic re);
      @(negedge clk_i);
      en_i = en; branch_i = br; branchTarget_i = bt; trap_i = tr; trapVector_i = tv;
      call_i = ca; ret_i = re;
      @(posedge clk_i);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] exp_seq [3];
      exp_seq[0] = 32'h104; exp_seq[1] = 32'h108; exp_seq[2] = 32'h10C;
      rst_i = 1'b1;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      if (pc_o !== 32'h100) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc_o, 32'h100); end
      n_cmp++;
      if (misaligned_o !== 1'b0 || pending_o !== 1'b0 || rasEmpty_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_flags got mis=%b pend=%b empty=%b want 0 0 1", misaligned_o, pending_o, rasEmpty_o);
      end
      n_cmp++;
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, 0, 0, 0);
         if (pc_o !== exp_seq[i] || misaligned_o !== 1'b0 || pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_%0d got pc=%h mis=%b pend=%b want pc=%h 0 0", i, pc_o, misaligned_o, pending_o, exp_seq[i]);
         end
         n_cmp++;
      end
   endtask

   task automatic test_stall_buffer();
      cyc(0, 1, 32'h2000, 0, 0, 0, 0);
      if (pc_o !== 32'h10C || pending_o !== 1'b1) begin
         n_fail++; $display("FAIL stall1 got pc=%h pend=%b want 10c 1", pc_o, pending_o);
      end
      n_cmp++;
      cyc(0, 0, 0, 1, 32'h80, 0, 0);
      if (pc_o !== 32'h10C || pending_o !== 1'b1) begin
         n_fail++; $display("FAIL stall2 got pc=%h pend=%b want 10c 1", pc_o, pending_o);
      end
      n_cmp++;
      cyc(0, 1, 32'h3000, 0, 0, 0, 0);
      if (pc_o !== 32'h10C || pending_o !== 1'b1) begin
         n_fail++; $display("FAIL stall3 got pc=%h pend=%b want 10c 1", pc_o, pending_o);
      end
      n_cmp++;
      cyc(1, 0, 0, 0, 0, 0, 0);
      if (pc_o !== 32'h80 || pending_o !== 1'b0 || misaligned_o !== 1'b0) begin
         n_fail++; $display("FAIL stall_release got pc=%h pend=%b mis=%b want 80 0 0", pc_o, pending_o, misaligned_o);
      end
      n_cmp++;
   endtask

   task automatic test_priority();
      cyc(1, 1, 32'h500, 1, 32'h600, 0, 0);
      if (pc_o !== 32'h600) begin n_fail++; $display("FAIL trap_over_branch got %h want 600", pc_o); end
      n_cmp++;
      // stalled branch superseded by a current branch on the enabled edge
      cyc(0, 1, 32'h700, 0, 0, 0, 0);
      cyc(1, 1, 32'h900, 0, 0, 0, 0);
      if (pc_o !== 32'h900 || pending_o !== 1'b0) begin
         n_fail++; $display("FAIL current_over_buffer got pc=%h pend=%b want 900 0", pc_o, pending_o);
      end
      n_cmp++;
   endtask

   task automatic test_misaligned();
      cyc(1, 1, 32'h1003, 0, 0, 0, 0);
      if (pc_o !== 32'h1000 || misaligned_o !== 1'b1) begin
         n_fail++; $display("FAIL misaligned_load got pc=%h mis=%b want 1000 1", pc_o, misaligned_o);
      end
      n_cmp++;
      cyc(1, 0, 0, 0, 0, 0, 0);
      if (pc_o !== 32'h1004 || misaligned_o !== 1'b0) begin
         n_fail++; $display("FAIL misaligned_clear got pc=%h mis=%b want 1004 0", pc_o, misaligned_o);
      end
      n_cmp++;
   endtask

   task automatic test_wrap();
      cyc(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      if (pc_o !== 32'hFFFF_FFFC || pcPlus4_o !== 32'h0) begin
         n_fail++; $display("FAIL wrap_plus4 got pc=%h p4=%h want fffffffc 0", pc_o, pcPlus4_o);
      end
      n_cmp++;
      cyc(1, 0, 0, 0, 0, 0, 0);
      if (pc_o !== 32'h0 || pcPlus4_o !== 32'h4) begin
         n_fail++; $display("FAIL wrap_pc got pc=%h p4=%h want 0 4", pc_o, pcPlus4_o);
      end
      n_cmp++;
   endtask

`ifdef PC_RAS_EN
   task automatic test_ras();
      logic [31:0] exp_ret [4];
      exp_ret[0] = 32'h54; exp_ret[1] = 32'h44; exp_ret[2] = 32'h34; exp_ret[3] = 32'h24;
      cyc(1, 1, 32'h10, 0, 0, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         cyc(1, 0, 0, 0, 0, 1, 0);
         if (pc_o !== 32'(k * 16 + 4) || rasEmpty_o !== 1'b0) begin
            n_fail++; $display("FAIL ras_call_%0d got pc=%h empty=%b want %h 0", k, pc_o, rasEmpty_o, k * 16 + 4);
         end
         n_cmp++;
         if (k < 5) cyc(1, 1, 32'((k + 1) * 16), 0, 0, 0, 0);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, 0, 0, 0, 1);
         if (pc_o !== exp_ret[i] || rasEmpty_o !== (i == 3)) begin
            n_fail++; $display("FAIL ras_ret_%0d got pc=%h empty=%b want %h %b", i, pc_o, rasEmpty_o, exp_ret[i], i == 3);
         end
         n_cmp++;
      end
      cyc(1, 0, 0, 0, 0, 0, 1);
      if (pc_o !== 32'h28 || rasEmpty_o !== 1'b1) begin
         n_fail++; $display("FAIL ras_underflow got pc=%h empty=%b want 28 1", pc_o, rasEmpty_o);
      end
      n_cmp++;
      cyc(1, 0, 0, 0, 0, 1, 0);   // push 0x2c, pc 0x2c
      cyc(1, 0, 0, 0, 0, 1, 1);   // next = 0x2c, top becomes 0x30
      cyc(1, 0, 0, 0, 0, 0, 1);
      if (pc_o !== 32'h30 || rasEmpty_o !== 1'b1) begin
         n_fail++; $display("FAIL ras_call_ret got pc=%h empty=%b want 30 1", pc_o, rasEmpty_o);
      end
      n_cmp++;
   endtask
`endif

   task automatic test_async_reset();
      cyc(1, 1, 32'h3000, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 1, 0);
      cyc(0, 1, 32'h4001, 0, 0, 0, 0);
      if (pending_o !== 1'b1) begin n_fail++; $display("FAIL pre_reset_pending got %b want 1", pending_o); end
      n_cmp++;
      @(negedge clk_i);
      en_i = 1'b0; branch_i = 1'b0; call_i = 1'b0;
      #2 rst_i = 1'b1;
      #1;
      model_reset();
      if (pc_o !== RV || pending_o !== 1'b0 || rasEmpty_o !== 1'b1 || misaligned_o !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got pc=%h pend=%b empty=%b mis=%b want %h 0 1 0", pc_o, pending_o, rasEmpty_o, misaligned_o, RV);
      end
      n_cmp++;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic test_random();
      logic exp_empty;
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom % 4) != 0, ($urandom % 5) == 0, $urandom,
             ($urandom % 10) == 0, $urandom, ($urandom % 4) == 0, ($urandom % 4) == 0);
`ifdef PC_RAS_EN
         exp_empty = (m_ras.size() == 0);
`else
         exp_empty = 1'b1;
`endif
         if (pc_o !== m_pc) begin n_fail++; $display("FAIL rnd_pc %0d got %h want %h", i, pc_o, m_pc); end
         n_cmp++;
         if (pcPlus4_o !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_p4 %0d got %h want %h", i, pcPlus4_o, m_pc + 32'd4); end
         n_cmp++;
         if (misaligned_o !== m_mis) begin n_fail++; $display("FAIL rnd_mis %0d got %b want %b", i, misaligned_o, m_mis); end
         n_cmp++;
         if (pending_o !== m_pv) begin n_fail++; $display("FAIL rnd_pend %0d got %b want %b", i, pending_o, m_pv); end
         n_cmp++;
         if (rasEmpty_o !== exp_empty) begin n_fail++; $display("FAIL rnd_empty %0d got %b want %b", i, rasEmpty_o, exp_empty); end
         n_cmp++;
      end
   endtask

   initial begin
      test_reset();
      test_stall_buffer();
      test_priority();
      test_misaligned();
      test_wrap();
`ifdef PC_RAS_EN
      test_ras();
`endif
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
